// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch stage and the rest of the MIPS datapath.
package ifu_pkg;

    // Fetch entry as seen by decode (32-bit datapath view).
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcodes used across the datapath.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // A fetch address must be word aligned; any nonzero low bit is a fault.
    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead FIFO with synchronous flush. Head entry is visible whenever valid=1.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Ignore pops on an empty FIFO so the count can never underflow.
    always_comb begin
        pop_s = pop && (count_r != '0);
    end

    // Pointer, occupancy and storage update; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop_s);
        end
    end

    assign head_data = store_r[rd_ptr_r];
    assign valid     = (count_r != '0);
    assign count     = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, synchronous-read instruction memory and show-ahead output buffer.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      prog_we,
    input  logic [$clog2(DEPTH)-1:0]  prog_addr,
    input  logic [DATA_W-1:0]         prog_data,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [ADDR_W-1:0]         out_pc_plus4,
    output logic                      fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;
    logic [ADDR_W-1:0] rd_pc_r;
    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic              fault_r;

    logic              pop_s;
    logic [CNT_W:0]    occ_s;
    logic              room_s;
    logic              attempt_s;
    logic              bad_pc_s;
    logic              issue_s;
    logic              push_s;
    logic [CNT_W-1:0]  count_s;
    logic              fifo_valid_s;
    logic [ENT_W-1:0]  push_ent_s;
    logic [ENT_W-1:0]  head_ent_s;

    // Issue decision: room is counted including the read in flight and the entry leaving now.
    always_comb begin
        pop_s     = fifo_valid_s && out_ready;
        occ_s     = {1'b0, count_s} + (CNT_W + 1)'(inflight_r) - (CNT_W + 1)'(pop_s);
        room_s    = (occ_s < (CNT_W + 1)'(FIFO_DEPTH));
        attempt_s = !fault_r && !redirect_valid && room_s;
        bad_pc_s  = ({1'b0, pc_r} >= PC_LIMIT) || pc_misaligned(pc_r[1:0]);
        issue_s   = attempt_s && !bad_pc_s;
        push_s    = inflight_r && !redirect_valid;
    end

    // Program port; contents survive reset, and a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Synchronous memory read, registered only when a fetch is issued.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            rd_data_r <= mem_r[pc_r[IDX_W+1:2]];
        end
    end

    // PC, in-flight tracking and sticky fault; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            rd_pc_r    <= '0;
            inflight_r <= 1'b0;
            fault_r    <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= redirect_pc;
            inflight_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r    <= pc_r + ADDR_W'(4);
                rd_pc_r <= pc_r;
            end else if (attempt_s && bad_pc_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign push_ent_s = {rd_data_r, rd_pc_r};

    ifu_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_ent_s),
        .pop       (pop_s),
        .head_data (head_ent_s),
        .valid     (fifo_valid_s),
        .count     (count_s)
    );

    assign out_valid    = fifo_valid_s;
    assign out_instr    = head_ent_s[ENT_W-1:ADDR_W];
    assign out_pc       = head_ent_s[ADDR_W-1:0];
    assign out_pc_plus4 = head_ent_s[ADDR_W-1:0] + ADDR_W'(4);
    assign fault        = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with default parameters.
module tb_instr_fetch_unit;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 16;
    localparam int FIFO_DEPTH = 2;
    localparam logic [31:0] NEW_W3 = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              prog_we = 1'b0;
    logic [3:0]        prog_addr = 4'd0;
    logic [31:0]       prog_data = 32'd0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc_plus4;
    logic              fault;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int vcount;
    logic [31:0] prog [16];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
        chk({tag, "_instr"}, 64'(out_instr), 64'(instr));
        chk({tag, "_plus4"}, 64'(out_pc_plus4), 64'(pc + 32'd4));
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h0022_1820;   // add $3,$1,$2
        prog[1] = 32'h0022_2022;   // sub $4,$1,$2
        prog[2] = 32'h0022_2825;   // or  $5,$1,$2
        prog[3] = 32'h8C06_0000;   // lw  $6,0($0)
        prog[4] = 32'h0022_3824;   // and $7,$1,$2
        prog[5] = 32'hAC06_0004;   // sw  $6,4($0)
        prog[6] = 32'h1022_0001;   // beq $1,$2,1
        prog[7] = 32'h0800_0000;   // j   0
        for (int i = 8; i < 16; i++) begin
            prog[i] = 32'h2000_0000 | 32'(i);
        end

        // Load memory while held in reset.
        tick();
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_fault", 64'(fault), 64'(1'b0));

        // Sequential fetch, full throughput, runs past the end of memory.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("start_e1_valid", 64'(out_valid), 64'(1'b0));
        tick();
        for (int i = 0; i < 16; i++) begin
            check_out("seq", 32'(i * 4), prog[i]);
            chk("seq_fault", 64'(fault), 64'(i == 15));
            tick();
        end
        vcount = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) vcount++;
            tick();
        end
        chk("fault_no_valid", 64'(vcount), 64'd0);
        chk("fault_sticky", 64'(fault), 64'(1'b1));

        // Redirect to 0 clears the fault and restarts fetch.
        do_redirect(32'h0);
        chk("redir0_fault", 64'(fault), 64'(1'b0));
        chk("redir0_n", 64'(out_valid), 64'(1'b0));
        tick();
        chk("redir0_n1", 64'(out_valid), 64'(1'b0));
        tick();
        check_out("redir0_a", 32'h0, prog[0]);
        tick();
        check_out("redir0_b", 32'h4, prog[1]);

        // Misaligned redirect target faults with nothing delivered.
        do_redirect(32'h6);
        chk("mis_n_valid", 64'(out_valid), 64'(1'b0));
        tick();
        chk("mis_fault", 64'(fault), 64'(1'b1));
        vcount = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) vcount++;
            tick();
        end
        chk("mis_no_valid", 64'(vcount), 64'd0);

        // Asynchronous reset clears the fault between edges.
        #2 rst_n = 1'b0;
        #1 chk("arst_fault", 64'(fault), 64'(1'b0));
        tick();

        // Backpressure: hold out_ready low for 10 cycles after startup.
        out_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("bp_e1_valid", 64'(out_valid), 64'(1'b0));
        for (int k = 2; k <= 10; k++) begin
            tick();
            check_out("bp_hold", 32'h0, prog[0]);
        end
        for (int i = 0; i < 5; i++) begin
            check_out("bp_drain", 32'(i * 4), prog[i]);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check_out("bp_hold2", 32'h14, prog[5]);

        // Redirect while the buffer is full drops the buffered entries.
        do_redirect(32'h20);
        chk("rfull_n", 64'(out_valid), 64'(1'b0));
        tick();
        chk("rfull_n1", 64'(out_valid), 64'(1'b0));
        tick();
        check_out("rfull", 32'h20, prog[8]);

        // Mid-stream asynchronous reset with an entry visible.
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", 64'(out_valid), 64'(1'b0));
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("restart_e1", 64'(out_valid), 64'(1'b0));
        tick();
        check_out("restart", 32'h0, prog[0]);

        // Write word 3 on the edge that reads it: old data goes out, FIFO untouched.
        tick();
        check_out("wr_pre", 32'h4, prog[1]);
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = NEW_W3;
        tick();
        prog_we = 1'b0;
        check_out("wr_keep", 32'h8, prog[2]);
        tick();
        check_out("wr_old", 32'hC, prog[3]);
        prog[3] = NEW_W3;
        do_redirect(32'hC);
        tick();
        tick();
        check_out("wr_new", 32'hC, prog[3]);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
